// File: rtl/fir16_pkg.sv
// Shared widths, FSM state type and output saturation for the 16-tap FIR filter.
package fir16_pkg;

  localparam int unsigned NUM_TAPS = 16;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned COEFF_W  = 16;
  localparam int unsigned ACC_W    = 38;
  localparam int unsigned IDX_W    = $clog2(NUM_TAPS);
  localparam int unsigned PROD_W   = DATA_W + COEFF_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } fir_state_t;

  // Drop the Q0.16 fraction (floor) and clamp into the signed output range.
  function automatic logic signed [DATA_W-1:0] sat16(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] sh;
    sh = acc >>> COEFF_W;
    if (sh[ACC_W-1:DATA_W-1] == {(ACC_W-DATA_W+1){sh[ACC_W-1]}}) begin
      sat16 = sh[DATA_W-1:0];
    end else if (sh[ACC_W-1]) begin
      sat16 = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      sat16 = {1'b0, {(DATA_W-1){1'b1}}};
    end
  endfunction

endpackage

// File: rtl/fir16_tap_filter_if.sv
// Sequencer-facing bundle of the FIR filter: run/busy handshake, sample, result and coefficient bank.
interface fir16_tap_filter_if;
  import fir16_pkg::*;

  logic                                 run;
  logic                                 busy;
  logic signed [DATA_W-1:0]             sample_in;
  logic signed [DATA_W-1:0]             filter_data;
  logic        [NUM_TAPS-1:0][COEFF_W-1:0] coeff;

  modport master (
    output run,
    output sample_in,
    output coeff,
    input  busy,
    input  filter_data
  );

  modport slave (
    input  run,
    input  sample_in,
    input  coeff,
    output busy,
    output filter_data
  );

endinterface

// File: rtl/fir16_mac.sv
// One multiply-accumulate step: signed sample times unsigned Q0.16 coefficient added to the accumulator.
module fir16_mac
  import fir16_pkg::*;
(
  input  logic signed [ACC_W-1:0]   i_acc,
  input  logic signed [DATA_W-1:0]  i_sample,
  input  logic        [COEFF_W-1:0] i_coeff,
  output logic signed [ACC_W-1:0]   o_acc_c
);

  logic signed [DATA_W:0]   w_a;
  logic signed [COEFF_W:0]  w_b;
  logic signed [PROD_W-1:0] w_prod;

  // Both operands become 17-bit signed so a single signed multiply covers the unsigned coefficient.
  assign w_a    = {i_sample[DATA_W-1], i_sample};
  assign w_b    = {1'b0, i_coeff};
  assign w_prod = PROD_W'(w_a) * PROD_W'(w_b);

  assign o_acc_c = i_acc + ACC_W'(w_prod);

endmodule

// File: rtl/fir16_tap_filter.sv
// Sequential 16-tap FIR: one MAC per clock over a persistent delay line, saturated 16-bit result.
module fir16_tap_filter
  import fir16_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  fir16_tap_filter_if.slave  bus
);

  fir_state_t               r_state;
  fir_state_t               w_state_nxt;
  logic [IDX_W-1:0]         r_idx;
  logic [IDX_W-1:0]         w_idx_nxt;
  logic signed [ACC_W-1:0]  r_acc;
  logic signed [ACC_W-1:0]  w_acc_nxt;
  logic signed [ACC_W-1:0]  w_mac_c;
  logic signed [DATA_W-1:0] r_dline [NUM_TAPS];
  logic signed [DATA_W-1:0] r_filter_data;
  logic                     r_busy;
  logic                     w_busy_nxt;
  logic                     w_shift;
  logic                     w_load;
  logic signed [DATA_W-1:0] w_tap;
  logic        [COEFF_W-1:0] w_coeff;

  assign bus.busy        = r_busy;
  assign bus.filter_data = r_filter_data;

  // Tap index selects the delayed sample and its coefficient for this cycle.
  assign w_tap   = r_dline[r_idx];
  assign w_coeff = bus.coeff[r_idx];

  fir16_mac u_mac (
    .i_acc    (r_acc),
    .i_sample (w_tap),
    .i_coeff  (w_coeff),
    .o_acc_c  (w_mac_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath control; run during MAC/DONE falls through untouched.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_acc_nxt   = r_acc;
    w_busy_nxt  = r_busy;
    w_shift     = 1'b0;
    w_load      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.run) begin
          w_state_nxt = MAC;
          w_idx_nxt   = '0;
          w_acc_nxt   = '0;
          w_busy_nxt  = 1'b1;
          w_shift     = 1'b1;
        end
      end
      MAC: begin
        w_acc_nxt = w_mac_c;
        w_idx_nxt = r_idx + IDX_W'(1);
        if (r_idx == IDX_W'(NUM_TAPS - 1)) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
        w_busy_nxt  = 1'b0;
        w_load      = 1'b1;
      end
      default: begin
        w_state_nxt = IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx         <= '0;
      r_acc         <= '0;
      r_busy        <= 1'b0;
      r_filter_data <= '0;
    end else begin
      r_idx  <= w_idx_nxt;
      r_acc  <= w_acc_nxt;
      r_busy <= w_busy_nxt;
      if (w_load) begin
        r_filter_data <= sat16(r_acc);
      end
    end
  end

  // Delay line survives across runs; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_TAPS); i++) begin
        r_dline[i] <= '0;
      end
    end else if (w_shift) begin
      r_dline[0] <= bus.sample_in;
      for (int i = 1; i < int'(NUM_TAPS); i++) begin
        r_dline[i] <= r_dline[i-1];
      end
    end
  end

endmodule

// File: tb/tb_fir16_tap_filter.sv
// Randomized and directed bench for fir16_tap_filter with a queue-based scoreboard and arithmetic reference model.
module tb_fir16_tap_filter;
  import fir16_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  fir16_tap_filter_if bus ();

  fir16_tap_filter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int hist[$];
  int coef[NUM_TAPS];

  task automatic check(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  // Reference: sum of sample*coefficient over the last 16 samples, floor-divided by 2^16, clamped.
  function automatic int model_output();
    longint acc;
    acc = 0;
    for (int k = 0; k < int'(NUM_TAPS); k++) begin
      acc += longint'(hist[k]) * longint'(coef[k]);
    end
    acc = acc >>> 16;
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
    return int'(acc);
  endfunction

  function automatic void model_clear();
    hist.delete();
    for (int k = 0; k < int'(NUM_TAPS); k++) hist.push_back(0);
  endfunction

  function automatic void model_accept(input int s);
    hist.push_front(s);
    hist = hist[0:NUM_TAPS-1];
    exp_q.push_back(model_output());
  endfunction

  task automatic apply_bank();
    for (int k = 0; k < int'(NUM_TAPS); k++) bus.coeff[k] = 16'(coef[k]);
  endtask

  task automatic fill_bank(input int lo_val, input int hi_val, input int split);
    for (int k = 0; k < int'(NUM_TAPS); k++) coef[k] = (k < split) ? lo_val : hi_val;
    apply_bank();
  endtask

  // Monitor: every busy fall outside reset is one completed output.
  int   busy_cycles = 0;
  logic prev_busy   = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_busy   = 1'b0;
      busy_cycles = 0;
    end else begin
      if (bus.busy) busy_cycles++;
      if (prev_busy && !bus.busy) begin
        check("busy_len", busy_cycles, 17);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %0d expected none", int'(bus.filter_data));
        end else begin
          check("filter_data", int'(bus.filter_data), exp_q.pop_front());
        end
        busy_cycles = 0;
      end
      prev_busy = bus.busy;
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy !== 1'b0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (bus.busy !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got busy=%b expected 0", bus.busy);
    end
  endtask

  task automatic do_run(input int s);
    wait_idle();
    bus.sample_in = 16'(s);
    bus.run       = 1'b1;
    model_accept(s);
    @(posedge clk);
    #1;
    bus.run = 1'b0;
    check("busy_rise", int'(bus.busy), 1);
  endtask

  task automatic run_expect(input int s, input string name, input int exp_v);
    do_run(s);
    wait_idle();
    check(name, int'(bus.filter_data), exp_v);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_busy", int'(bus.busy), 0);
    check("rst_data", int'(bus.filter_data), 0);
    exp_q.delete();
    model_clear();
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    bus.run       = 1'b0;
    bus.sample_in = '0;
    fill_bank(0, 0, 0);
    model_clear();

    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", int'(bus.busy), 0);
    check("reset_data", int'(bus.filter_data), 0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Passthrough bank, then reset in the middle of a computation.
    fill_bank(16'hFFFF, 0, 1);
    run_expect(1234, "pass_1234", 1233);
    do_run(2000);
    repeat (5) @(posedge clk);
    #1;
    do_reset();
    check("post_rst_data", int'(bus.filter_data), 0);
    run_expect(1000, "pass_1000", 999);
    run_expect(-1000, "pass_m1000", -1000);

    // Moving average over a cleared delay line.
    do_reset();
    fill_bank(16'h1000, 16'h1000, 16);
    for (int i = 1; i <= 16; i++) run_expect(160, "mavg", 10 * i);
    run_expect(0, "mavg_drain", 150);

    // Half-window average.
    fill_bank(16'h2000, 0, 8);
    for (int i = 0; i < 8; i++) do_run(800);
    wait_idle();
    check("half_fill", int'(bus.filter_data), 800);
    for (int i = 0; i < 8; i++) do_run(0);
    wait_idle();
    check("half_drain", int'(bus.filter_data), 0);

    // Saturation at both rails.
    fill_bank(16'hFFFF, 16'hFFFF, 16);
    for (int i = 0; i < 16; i++) do_run(32767);
    wait_idle();
    check("sat_pos", int'(bus.filter_data), 32767);
    for (int i = 0; i < 16; i++) do_run(-32768);
    wait_idle();
    check("sat_neg", int'(bus.filter_data), -32768);

    // run pulsed while busy must be ignored.
    for (int k = 0; k < int'(NUM_TAPS); k++) coef[k] = int'($urandom_range(0, 16'hFFFF));
    apply_bank();
    do_run(-7321);
    repeat (4) @(posedge clk);
    #1;
    bus.sample_in = 16'(5000);
    bus.run       = 1'b1;
    @(posedge clk);
    #1;
    bus.run = 1'b0;
    do_run(12000);
    do_run(-300);

    // run held high across completion re-triggers on the first idle cycle.
    wait_idle();
    bus.sample_in = 16'(4321);
    bus.run       = 1'b1;
    model_accept(4321);
    @(posedge clk);
    #1;
    bus.sample_in = 16'(-2222);
    model_accept(-2222);
    wait_idle();
    @(posedge clk);
    #1;
    bus.run = 1'b0;
    check("held_retrigger", int'(bus.busy), 1);

    // Randomized coefficients, samples and idle gaps.
    for (int n = 0; n < 40; n++) begin
      wait_idle();
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      if ((n % 5) == 0) begin
        for (int k = 0; k < int'(NUM_TAPS); k++) coef[k] = int'($urandom_range(0, 16'hFFFF));
        apply_bank();
      end
      s = int'($urandom_range(0, 16'hFFFF)) - 32768;
      do_run(s);
    end

    wait_idle();
    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
